// File: rtl/rca_seq_ctrl.sv
// Sequences a 64-bit add through an external 16-bit ripple-carry slice, LSB chunk first.
// Latency: done pulses in the cycle after edge 4*SETTLE, where edge 0 is the accepted start.
// Backpressure: start is taken only while ready (IDLE); it is ignored in RUN and DONE.
module rca_seq_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic        ready,
    output logic        done,
    output logic [63:0] sum,
    output logic        c_out,
    output logic [15:0] slice_a,
    output logic [15:0] slice_b,
    output logic        slice_cin,
    input  logic [15:0] slice_sum,
    input  logic        slice_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] a_reg;
    logic [63:0] b_reg;
    // Only chunks 0..2 need holding; chunk 3 goes straight from the slice into sum.
    logic [47:0] acc;
    logic [1:0]  idx;
    logic [3:0]  cnt;
    logic        cy;
    logic        cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                slice_a   = a_reg[{idx, 4'b0000} +: 16];
                slice_b   = b_reg[{idx, 4'b0000} +: 16];
                slice_cin = cy;
                if (cnt_last && (idx == 2'd3)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            idx   <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        cy    <= c_in;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (cnt_last) begin
                        cy  <= slice_cout;
                        cnt <= '0;
                        if (idx == 2'd3) begin
                            sum   <= {slice_sum, acc};
                            c_out <= slice_cout;
                        end else begin
                            acc[{idx, 4'b0000} +: 16] <= slice_sum;
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and randomized checks of rca_seq_ctrl against a combinational 16-bit slice model.
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start1;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;

    logic        ready,  done,  c_out;
    logic [63:0] sum;
    logic [15:0] slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_cout;

    logic        ready1, done1, c_out1;
    logic [63:0] sum1;
    logic [15:0] slice_a1, slice_b1, slice_sum1;
    logic        slice_cin1, slice_cout1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {slice_cout, slice_sum}   = {1'b0, slice_a}  + {1'b0, slice_b}  + {16'd0, slice_cin};
    assign {slice_cout1, slice_sum1} = {1'b0, slice_a1} + {1'b0, slice_b1} + {16'd0, slice_cin1};

    rca_seq_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .ready(ready), .done(done), .sum(sum), .c_out(c_out),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout)
    );

    rca_seq_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .c_in(c_in),
        .ready(ready1), .done(done1), .sum(sum1), .c_out(c_out1),
        .slice_a(slice_a1), .slice_b(slice_b1), .slice_cin(slice_cin1),
        .slice_sum(slice_sum1), .slice_cout(slice_cout1)
    );

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; start1 = 1'b1;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; c_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sum !== 64'h0 || c_out !== 1'b0) begin errors++; $display("FAIL reset_sum got %h/%b want 0/0", sum, c_out); end
        checks++; if ({slice_a, slice_b, slice_cin} !== 33'h0) begin errors++; $display("FAIL reset_slice got %h %h %b want 0", slice_a, slice_b, slice_cin); end
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL start_with_rst got ready %b/%b want 1/1", ready, ready1); end
    endtask

    task automatic test_full_carry;
        int dcyc = -1; int npulse = 0; int rbad = 0;
        logic rdy10 = 1'b0; logic cin3 = 1'b0; logic [32:0] sl1 = '0;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; c_in = 1'b0; start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin start = 1'b0; sl1 = {slice_a, slice_b, slice_cin}; end
            if (k == 3) cin3 = slice_cin;
            if (k <= 9 && ready) rbad++;
            if (k == 10) rdy10 = ready;
            if (done) begin npulse++; if (dcyc < 0) dcyc = k; end
        end
        checks++; if (dcyc != 9 || npulse != 1) begin errors++; $display("FAIL fc_done_cycle got %0d (pulses %0d) want 9 (1)", dcyc, npulse); end
        checks++; if (rbad != 0 || rdy10 !== 1'b1) begin errors++; $display("FAIL fc_ready got low-violations %0d ready10 %b want 0/1", rbad, rdy10); end
        checks++; if (sl1 !== {16'hFFFF, 16'h0001, 1'b0}) begin errors++; $display("FAIL fc_chunk0_drive got %h want %h", sl1, {16'hFFFF, 16'h0001, 1'b0}); end
        checks++; if (cin3 !== 1'b1) begin errors++; $display("FAIL fc_chunk1_cin got %b want 1", cin3); end
        checks++; if (sum !== 64'h0 || c_out !== 1'b1) begin errors++; $display("FAIL fc_result got %h/%b want 0/1", sum, c_out); end
    endtask

    task automatic test_cin_only;
        int dcyc = -1; logic [7:0] mask = '0; logic [63:0] sum8 = '1;
        a = 64'h0; b = 64'h0; c_in = 1'b1; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k <= 8) mask[k-1] = slice_cin;
            if (k == 8) sum8 = sum;
            if (done && dcyc < 0) dcyc = k;
        end
        checks++; if (mask !== 8'b0000_0011) begin errors++; $display("FAIL cin_mask got %b want 00000011", mask); end
        checks++; if (sum8 !== 64'h0) begin errors++; $display("FAIL cin_hold_prev got %h want 0", sum8); end
        checks++; if (dcyc != 9 || sum !== 64'h1 || c_out !== 1'b0) begin errors++; $display("FAIL cin_result got cyc %0d %h/%b want 9 1/0", dcyc, sum, c_out); end
    endtask

    task automatic test_chunk_carry;
        logic [7:0] mask = '0;
        a = 64'h0000_FFFF_0000_FFFF; b = 64'h0000_0001_0000_0001; c_in = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k <= 8) mask[k-1] = slice_cin;
        end
        checks++; if (mask !== 8'b1100_1100) begin errors++; $display("FAIL cc_mask got %b want 11001100", mask); end
        checks++; if (sum !== 64'h0001_0000_0001_0000 || c_out !== 1'b0) begin errors++; $display("FAIL cc_result got %h/%b want 0001000000010000/0", sum, c_out); end
    endtask

    task automatic test_back_to_back;
        int npulse = 0; logic d9 = 1'b0; logic r10 = 1'b0; logic r11 = 1'b1; logic d19 = 1'b0;
        logic [64:0] res9 = '0;
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; c_in = 1'b1; start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin a = ~a; b = ~b; c_in = 1'b0; end
            if (k <= 18 && done) npulse++;
            if (k == 9) begin d9 = done; res9 = {c_out, sum}; end
            if (k == 10) r10 = ready;
            if (k == 11) begin r11 = ready; start = 1'b0; end
            if (k == 19) d19 = done;
        end
        checks++; if (npulse != 1 || d9 !== 1'b1) begin errors++; $display("FAIL b2b_pulses got %0d (done9 %b) want 1 (1)", npulse, d9); end
        checks++; if (res9 !== {1'b0, 64'h2222_2222_2222_2212}) begin errors++; $display("FAIL b2b_first_result got %h want 02222222222222212", res9); end
        checks++; if (r10 !== 1'b1 || r11 !== 1'b0) begin errors++; $display("FAIL b2b_reaccept got ready10 %b ready11 %b want 1/0", r10, r11); end
        checks++; if (d19 !== 1'b1 || {c_out, sum} !== {1'b1, 64'hDDDD_DDDD_DDDD_DDED}) begin errors++; $display("FAIL b2b_second_result got done %b %h want 1 1DDDDDDDDDDDDDDED", d19, {c_out, sum}); end
    endtask

    task automatic test_reset_mid;
        int npulse = 0; logic r6 = 1'b0; logic r7 = 1'b0; logic [64:0] res6 = '1; logic [32:0] sl6 = '1;
        a = 64'h5; b = 64'h6; c_in = 1'b0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done) npulse++;
            if (k == 5) begin rst = 1'b1; start = 1'b1; end
            if (k == 6) begin
                r6 = ready; res6 = {c_out, sum}; sl6 = {slice_a, slice_b, slice_cin};
                rst = 1'b0; start = 1'b0;
            end
            if (k == 7) r7 = ready;
        end
        checks++; if (r6 !== 1'b1 || r7 !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b/%b want 1/1", r6, r7); end
        checks++; if (res6 !== 65'h0 || sl6 !== 33'h0) begin errors++; $display("FAIL rmid_clear got %h slice %h want 0/0", res6, sl6); end
        checks++; if (npulse != 0 || {c_out, sum} !== 65'h0) begin errors++; $display("FAIL rmid_discard got pulses %0d result %h want 0/0", npulse, {c_out, sum}); end
    endtask

    task automatic test_settle1;
        int dcyc = -1; int npulse = 0;
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL s1_idle got %b want 1", ready1); end
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; c_in = 1'b0; start1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) start1 = 1'b0;
            if (done1) begin npulse++; if (dcyc < 0) dcyc = k; end
        end
        checks++; if (dcyc != 5 || npulse != 1) begin errors++; $display("FAIL s1_done_cycle got %0d (pulses %0d) want 5 (1)", dcyc, npulse); end
        checks++; if (sum1 !== 64'h0 || c_out1 !== 1'b1) begin errors++; $display("FAIL s1_result got %h/%b want 0/1", sum1, c_out1); end
    endtask

    task automatic test_random;
        logic [64:0] exp_res;
        bit got;
        for (int n = 0; n < 1000; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c_in = 1'($urandom_range(0, 1));
            if (n % 17 == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
            if (n % 23 == 0) b = ~a;
            exp_res = {1'b0, a} + {1'b0, b} + {64'd0, c_in};
            start = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(posedge clk); #1;
                start = 1'b0;
                a = {$urandom, $urandom};
                if (done) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL rnd_timeout op %0d got no done want done", n);
            end else if ({c_out, sum} !== exp_res) begin
                errors++; $display("FAIL rnd_result op %0d got %h want %h", n, {c_out, sum}, exp_res);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_carry();
        test_cin_only();
        test_chunk_carry();
        test_back_to_back();
        test_reset_mid();
        test_settle1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset, rst, SHALL be synchronous and active-high.
REQ-002 Parameter SETTLE, default 2, meaning the number of clk cycles each 16-bit slice operand set is held before its result is sampled; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin a 64-bit add; accepted only while ready=1.
REQ-006 a  input  64  operand A, sampled on the accepted start.
REQ-007 b  input  64  operand B, sampled on the accepted start.
REQ-008 c_in  input  1  carry-in, sampled on the accepted start.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 done  output  1  one-cycle pulse when sum/c_out are valid.
REQ-011 sum  output  64  registered 64-bit result.
REQ-012 c_out  output  1  registered carry-out.
REQ-013 slice_a  output  16  operand A chunk driven to the external 16-bit ripple-carry adder slice.
REQ-014 slice_b  output  16  operand B chunk driven to the slice.
REQ-015 slice_cin  output  1  carry driven to the slice.
REQ-016 slice_sum  input  16  slice sum, combinational from slice_a, slice_b and slice_cin.
REQ-017 slice_cout  input  1  slice carry-out.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 IDLE: ready=1, done=0, slice_a=0, slice_b=0, slice_cin=0.
- start=1 SHALL latch a, b and c_in into internal registers.
- It SHALL set chunk index idx=0, carry register cy=c_in and settle counter cnt=0, then go to RUN.
REQ-020 RUN SHALL drive slice_a=a_reg[16*idx+15:16*idx], slice_b=b_reg[16*idx+15:16*idx] and slice_cin=cy, with all three registered or driven from registers only.
REQ-021 RUN, cnt<SETTLE-1: cnt SHALL increment; nothing is captured.
REQ-022 RUN, cnt==SETTLE-1:
- acc[16*idx+15:16*idx] SHALL take slice_sum and cy SHALL take slice_cout.
- cnt SHALL clear.
- If idx<3, idx SHALL increment and the FSM stays in RUN.
- If idx==3, the FSM SHALL go to DONE.
REQ-023 On the RUN-to-DONE edge, sum SHALL load the completed accumulator (including the chunk captured on that edge) and c_out SHALL load slice_cout.
REQ-024 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-025 sum and c_out SHALL change only on the RUN-to-DONE edge and SHALL hold through IDLE and the next operation until its own DONE.
REQ-026 Latency: with the accepted start at edge 0, done SHALL be high in the cycle after edge 4*SETTLE; with SETTLE=2, done is high in cycle 9.
REQ-027 start SHALL be ignored in RUN and DONE, with no effect on operands or sequencing; the earliest next accept is the first IDLE cycle after DONE.
REQ-028 Changes to a, b or c_in after acceptance SHALL NOT affect the current result.
REQ-029 With SETTLE=1, each chunk SHALL be sampled in the first RUN cycle it is driven.
REQ-030 Arithmetic: {c_out,sum} SHALL equal a+b+c_in modulo 2^65, with carry chained chunk 0 (LSB) to chunk 3 (MSB).

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, ready=1, done=0, sum=0, c_out=0, idx=0, cnt=0, cy=0 and slice outputs=0, in any state, including mid-RUN.
REQ-032 An operation interrupted by rst SHALL be discarded: no done pulse and no update to sum/c_out.
REQ-033 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-034 The bench SHALL model the slice as a combinational 16-bit adder and cover these directed scenarios with SETTLE=2:
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1, c_in=0 -> sum=0, c_out=1, done in cycle 9 after start, ready low cycles 1-9.
- a=0, b=0, c_in=1 -> sum=64'h1, c_out=0; slice_cin=1 only during chunk 0.
- a=64'h0000_FFFF_0000_FFFF, b=64'h0000_0001_0000_0001, c_in=0 -> sum=64'h0001_0000_0001_0000, c_out=0 (carry across chunk boundaries).
- start held high plus operands changed during RUN -> one done pulse, result from the first operands, next accept on the first IDLE cycle.
- rst asserted in cycle 5 of an operation -> no done, sum/c_out keep their previous value after clearing to 0, ready=1 the next cycle.
- SETTLE=1 rerun of the first scenario -> done in cycle 5, same result.
REQ-035 A randomized run of at least 1000 operations SHALL match {c_out,sum}=a+b+c_in.
